// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with two-entry skid buffer, flush and stall counter
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);
  // bit 0 is main_v and bit 1 is skid_v, so both handshake outputs come directly from the state flops
  typedef enum logic [1:0] {EMPTY = 2'b00, FULL = 2'b01, SKID = 2'b11} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] main_d, main_d_n, skid_d, skid_d_n;
  logic [CNT_W-1:0] cnt_n;
  logic accept, deliver;
  assign out_valid = state[0];
  assign in_ready = ~state[1];
  assign out_data = main_d;
  assign accept = in_valid & in_ready;
  assign deliver = out_valid & out_ready;
  always_comb begin
    state_n = state;
    main_d_n = main_d;
    skid_d_n = skid_d;
    case (state)
      EMPTY: if (accept) begin
        state_n = FULL;
        main_d_n = in_data;
      end
      FULL: if (accept & deliver) main_d_n = in_data;
      else if (accept) begin
        state_n = SKID;
        skid_d_n = in_data;
      end else if (deliver) begin
        state_n = EMPTY;
        main_d_n = BUBBLE_VAL;
      end
      SKID: if (deliver) begin
        state_n = FULL;
        main_d_n = skid_d;
        skid_d_n = BUBBLE_VAL;
      end
      default: state_n = EMPTY;
    endcase
    if (flush) begin
      state_n = EMPTY;
      main_d_n = BUBBLE_VAL;
      skid_d_n = BUBBLE_VAL;
    end
    cnt_n = cnt_clr ? '0 : (out_valid & ~out_ready & ~&stall_cnt) ? stall_cnt + CNT_W'(1) : stall_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      main_d <= BUBBLE_VAL;
      skid_d <= BUBBLE_VAL;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      main_d <= main_d_n;
      skid_d <= skid_d_n;
      stall_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a queue-based model
module tb_pipe_stage_reg;
  localparam logic [15:0] BUB = 16'hDEAD;
  logic clk = 0, rst, in_valid, in_ready, in_ready2, out_valid, out_valid2, out_ready, flush, cnt_clr;
  logic [15:0] in_data, out_data, out_data2, stall_cnt;
  logic [1:0] stall_cnt2;
  int total = 0, bad = 0;
  logic [15:0] q[$];
  int mcnt = 0, mcnt2 = 0;
  bit started = 0;
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(16), .BUBBLE_VAL(BUB), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt));
  pipe_stage_reg #(.DATA_W(16), .BUBBLE_VAL(BUB), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt2));
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", n, a, e, $time);
    end
  endtask
  // The model is a FIFO of at most two payloads; a flush empties it and a full FIFO refuses input
  always @(posedge clk) begin
    bit acc, del, stl;
    acc = in_valid && q.size() < 2;
    del = q.size() > 0 && out_ready;
    stl = q.size() > 0 && !out_ready;
    if (rst) begin
      q.delete();
      mcnt = 0;
      mcnt2 = 0;
    end else begin
      if (flush) q.delete();
      else begin
        if (del) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
      if (cnt_clr) begin
        mcnt = 0;
        mcnt2 = 0;
      end else if (stl) begin
        mcnt = mcnt < 65535 ? mcnt + 1 : mcnt;
        mcnt2 = mcnt2 < 3 ? mcnt2 + 1 : mcnt2;
      end
    end
    started = 1;
  end
  always @(negedge clk) if (started) begin
    chk("m_valid", out_valid, q.size() > 0);
    chk("m_data", out_data, q.size() > 0 ? q[0] : BUB);
    chk("m_ready", in_ready, q.size() < 2);
    chk("m_cnt", stall_cnt, mcnt);
    chk("m2_valid", out_valid2, q.size() > 0);
    chk("m2_data", out_data2, q.size() > 0 ? q[0] : BUB);
    chk("m2_ready", in_ready2, q.size() < 2);
    chk("m2_cnt", stall_cnt2, mcnt2);
  end
  task automatic cyc(bit r, bit iv, logic [15:0] d, bit ordy, bit fl, bit cc);
    rst = r; in_valid = iv; in_data = d; out_ready = ordy; flush = fl; cnt_clr = cc;
    @(posedge clk);
    #2;
  endtask
  task automatic expect_out(string n, bit v, logic [15:0] d, bit rdy, logic [15:0] c);
    chk({n, "_valid"}, out_valid, v);
    chk({n, "_data"}, out_data, d);
    chk({n, "_ready"}, in_ready, rdy);
    chk({n, "_cnt"}, stall_cnt, c);
  endtask
  initial begin
    cyc(1, 1, 16'hAA, 0, 0, 0); expect_out("rst0", 0, BUB, 1, 0);
    cyc(1, 1, 16'hAA, 0, 0, 0); expect_out("rst1", 0, BUB, 1, 0);
    cyc(0, 0, 16'h0, 1, 0, 0); expect_out("rst_rel", 0, BUB, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 16'(i), 1, 0, 0);
      expect_out("stream", 1, 16'(i), 1, 0);
    end
    cyc(0, 0, 16'h0, 1, 0, 0); expect_out("stream_end", 0, BUB, 1, 0);
    cyc(0, 1, 16'h10, 0, 0, 0); expect_out("skid_a", 1, 16'h10, 1, 0);
    cyc(0, 1, 16'h11, 0, 0, 0); expect_out("skid_b", 1, 16'h10, 0, 1);
    for (int i = 2; i <= 4; i++) begin
      cyc(0, 0, 16'h0, 0, 0, 0);
      expect_out("skid_hold", 1, 16'h10, 0, 16'(i));
    end
    cyc(0, 0, 16'h0, 1, 0, 0); expect_out("skid_rel", 1, 16'h11, 1, 4);
    cyc(0, 0, 16'h0, 1, 0, 0); expect_out("skid_drain", 0, BUB, 1, 4);
    cyc(0, 1, 16'h20, 0, 0, 0);
    cyc(0, 1, 16'h21, 0, 0, 0); expect_out("fl_fill", 1, 16'h20, 0, 5);
    cyc(0, 1, 16'h22, 0, 0, 0); expect_out("fl_blocked", 1, 16'h20, 0, 6);
    cyc(0, 1, 16'h55, 0, 1, 0); expect_out("flush", 0, BUB, 1, 7);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 16'h0, 1, 0, 0);
      chk("no_55", out_data == 16'h55, 0);
      expect_out("post_flush", 0, BUB, 1, 7);
    end
    cyc(0, 1, 16'h30, 1, 0, 0); expect_out("flush_acc", 1, 16'h30, 1, 7);
    cyc(0, 0, 16'h0, 1, 0, 0);
    cyc(0, 1, 16'h40, 0, 0, 1); expect_out("cnt_start", 1, 16'h40, 1, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 0, 16'h0, 0, 0, 0);
      chk("cnt2_sat", stall_cnt2, i < 3 ? i : 3);
    end
    chk("cnt16_six", stall_cnt, 6);
    cyc(0, 0, 16'h0, 0, 0, 1);
    chk("cnt2_clr", stall_cnt2, 0);
    chk("cnt16_clr", stall_cnt, 0);
    cyc(0, 0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 199) == 0, 1'($urandom), 16'($urandom), $urandom_range(0, 9) < 6,
          $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
    cyc(0, 0, 16'h0, 1, 0, 0);
    cyc(0, 0, 16'h0, 1, 0, 0);
    expect_out("final_empty", 0, BUB, 1, 16'(mcnt));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
